// File: rtl/touch_scan_scheduler_pkg.sv
// Shared definitions for the touchpad scan scheduler: control-byte layout,
// axis codes, calibration limits, reset coordinate and FSM state encoding.
// Optional feature macro used by the design: TOUCH_CAL_EN (calibrated x/y).
`ifndef TOUCH_SCAN_SCHEDULER_PKG_SV
`define TOUCH_SCAN_SCHEDULER_PKG_SV

package touch_scan_scheduler_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CMD_W  = 8;

    // Axis select codes carried in control-byte bits [2:1]
    localparam logic [1:0] AXIS_X = 2'b01;
    localparam logic [1:0] AXIS_Y = 2'b00;
    localparam logic [1:0] AXIS_Z = 2'b10;

    // Fixed control-byte fields
    localparam logic       CMD_START = 1'b1;
    localparam logic       CMD_REF   = 1'b1;
    localparam logic [1:0] CMD_MODE  = 2'b00;
    localparam logic [1:0] CMD_PWR   = 2'b11;

    // Calibration window (offset subtracted, then upper clamp)
    localparam logic [DATA_W-1:0] CAL_X_MIN = 12'h096;
    localparam logic [DATA_W-1:0] CAL_X_MAX = 12'hF6E;
    localparam logic [DATA_W-1:0] CAL_Y_MIN = 12'h12C;
    localparam logic [DATA_W-1:0] CAL_Y_MAX = 12'hED8;

    localparam logic [DATA_W-1:0] RESET_COORD = 12'd1000;

    // Control byte sent to the transaction engine
    typedef struct packed {
        logic [1:0] pwr;
        logic [1:0] mode;
        logic       ref_sel;
        logic [1:0] axis;
        logic       start;
    } txn_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PUBLISH,
        ST_GAP
    } state_t;

    function automatic txn_cmd_t make_cmd(input logic [1:0] axis);
        txn_cmd_t c;
        c.pwr     = CMD_PWR;
        c.mode    = CMD_MODE;
        c.ref_sel = CMD_REF;
        c.axis    = axis;
        c.start   = CMD_START;
        return c;
    endfunction

    // Saturating subtract of the offset, then clamp to the upper limit
    function automatic logic [DATA_W-1:0] cal_clamp(input logic [DATA_W-1:0] v,
                                                    input logic [DATA_W-1:0] off,
                                                    input logic [DATA_W-1:0] hi);
        logic [DATA_W-1:0] d;
        d = (v > off) ? (v - off) : '0;
        return (d > hi) ? hi : d;
    endfunction

endpackage

`endif

// File: rtl/touch_axis_avg.sv
// Per-axis sample averager: counts samples, drops the leading DISCARD
// samples, sums the following 2^REPS_LOG2 and reports the truncated mean.
// Ports:
//   cclk, rstb      clock, async active-low reset
//   clear           restart the axis (wins over sample_en)
//   sample_en       a sample is presented on sample this cycle
//   sample          12-bit conversion result
//   last_c          this sample completes the axis (combinational)
//   avg_c           mean including the current sample (combinational)
module touch_axis_avg
    import touch_scan_scheduler_pkg::*;
#(
    parameter int unsigned REPS_LOG2 = 2,
    parameter int unsigned DISCARD   = 1
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              clear,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample,
    output logic              last_c,
    output logic [DATA_W-1:0] avg_c
);

    localparam int unsigned TOTAL = DISCARD + (32'd1 << REPS_LOG2);
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned ACC_W = DATA_W + REPS_LOG2;

    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count_inc;
    logic             keep;
    logic [ACC_W-1:0] acc_sum;

    // Running sum including the sample on the bus, so the final mean is
    // available in the same cycle as the last done
    always_comb begin
        count_inc = count + CNT_W'(1);
        keep      = (count_inc > CNT_W'(DISCARD));
        acc_sum   = keep ? (acc + ACC_W'(sample)) : acc;
        last_c    = sample_en && (count_inc == CNT_W'(TOTAL));
        avg_c     = DATA_W'(acc_sum >> REPS_LOG2);
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            count <= '0;
            acc   <= '0;
        end else if (clear) begin
            count <= '0;
            acc   <= '0;
        end else if (sample_en) begin
            count <= count_inc;
            acc   <= acc_sum;
        end
    end

endmodule

// File: rtl/touch_scan_scheduler.sv
// Touchpad scan scheduler: issues X->Y->Z conversion transactions to the SPI
// engine over a req/done handshake, averages each axis, gates X/Y on
// pen-down and publishes registered coordinates with a one-cycle strobe.
// Optional macro TOUCH_CAL_EN: offset/clamp calibration of x and y.
// Ports:
//   cclk, rstb          clock, async active-low reset
//   enable              run scans while high
//   txn_req, txn_cmd    request level and control byte to the engine
//   txn_done, txn_rdata completion pulse and 12-bit result from the engine
//   x, y, z, pen_down   published coordinates and pen state
//   sample_valid        one-cycle strobe with each publish
//   timeout_err         one-cycle strobe when a transaction is abandoned
//   busy                high whenever the scheduler is not idle
module touch_scan_scheduler
    import touch_scan_scheduler_pkg::*;
#(
    parameter int unsigned       REPS_LOG2 = 2,
    parameter int unsigned       DISCARD   = 1,
    parameter int unsigned       SCAN_GAP  = 5000,
    parameter int unsigned       TIMEOUT   = 4096,
    parameter logic [DATA_W-1:0] Z_THRESH  = 12'h080
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              enable,
    output logic              txn_req,
    output logic [CMD_W-1:0]  txn_cmd,
    input  logic              txn_done,
    input  logic [DATA_W-1:0] txn_rdata,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] z,
    output logic              pen_down,
    output logic              sample_valid,
    output logic              timeout_err,
    output logic              busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(SCAN_GAP + 1);

    state_t            state, state_d;
    logic [1:0]        axis, axis_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
    logic [DATA_W-1:0] x_avg, x_avg_d, y_avg, y_avg_d, z_avg, z_avg_d;
    logic [DATA_W-1:0] x_d, y_d, z_d;
    logic [CMD_W-1:0]  txn_cmd_d;
    logic              txn_req_d, pen_down_d, sample_valid_d, timeout_err_d, busy_d;

    logic              avg_clear, avg_en, avg_last;
    logic [DATA_W-1:0] avg_val;
    logic [DATA_W-1:0] x_pub, y_pub;

    touch_axis_avg #(
        .REPS_LOG2 (REPS_LOG2),
        .DISCARD   (DISCARD)
    ) u_avg (
        .cclk      (cclk),
        .rstb      (rstb),
        .clear     (avg_clear),
        .sample_en (avg_en),
        .sample    (txn_rdata),
        .last_c    (avg_last),
        .avg_c     (avg_val)
    );

    // Values presented for x/y on a pen-down publish
`ifdef TOUCH_CAL_EN
    always_comb begin
        x_pub = cal_clamp(x_avg, CAL_X_MIN, CAL_X_MAX);
        y_pub = cal_clamp(y_avg, CAL_Y_MIN, CAL_Y_MAX);
    end
`else
    always_comb begin
        x_pub = x_avg;
        y_pub = y_avg;
    end
`endif

    // State and all registered outputs
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state        <= ST_IDLE;
            axis         <= AXIS_X;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            x_avg        <= '0;
            y_avg        <= '0;
            z_avg        <= '0;
            x            <= RESET_COORD;
            y            <= RESET_COORD;
            z            <= RESET_COORD;
            txn_cmd      <= '0;
            txn_req      <= 1'b0;
            pen_down     <= 1'b0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            axis         <= axis_d;
            tmo_cnt      <= tmo_cnt_d;
            gap_cnt      <= gap_cnt_d;
            x_avg        <= x_avg_d;
            y_avg        <= y_avg_d;
            z_avg        <= z_avg_d;
            x            <= x_d;
            y            <= y_d;
            z            <= z_d;
            txn_cmd      <= txn_cmd_d;
            txn_req      <= txn_req_d;
            pen_down     <= pen_down_d;
            sample_valid <= sample_valid_d;
            timeout_err  <= timeout_err_d;
            busy         <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        axis_d         = axis;
        tmo_cnt_d      = tmo_cnt;
        gap_cnt_d      = gap_cnt;
        x_avg_d        = x_avg;
        y_avg_d        = y_avg;
        z_avg_d        = z_avg;
        x_d            = x;
        y_d            = y;
        z_d            = z;
        txn_cmd_d      = txn_cmd;
        txn_req_d      = txn_req;
        pen_down_d     = pen_down;
        sample_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
        avg_clear      = 1'b0;
        avg_en         = 1'b0;

        case (state)
            ST_IDLE: begin
                avg_clear = 1'b1;
                if (enable) begin
                    axis_d  = AXIS_X;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                txn_cmd_d = make_cmd(axis);
                txn_req_d = 1'b1;
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end

            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt + TMO_W'(1);
                // done is checked first so it wins over a same-cycle timeout
                if (txn_done) begin
                    txn_req_d = 1'b0;
                    if (!enable) begin
                        avg_clear = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        avg_en = 1'b1;
                        if (avg_last) begin
                            avg_clear = 1'b1;
                            case (axis)
                                AXIS_X: begin
                                    x_avg_d = avg_val;
                                    axis_d  = AXIS_Y;
                                    state_d = ST_ISSUE;
                                end
                                AXIS_Y: begin
                                    y_avg_d = avg_val;
                                    axis_d  = AXIS_Z;
                                    state_d = ST_ISSUE;
                                end
                                default: begin
                                    z_avg_d = avg_val;
                                    state_d = ST_PUBLISH;
                                end
                            endcase
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    txn_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    avg_clear     = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = ST_GAP;
                end
            end

            ST_PUBLISH: begin
                avg_clear      = 1'b1;
                sample_valid_d = 1'b1;
                z_d            = z_avg;
                if (z_avg >= Z_THRESH) begin
                    x_d        = x_pub;
                    y_d        = y_pub;
                    pen_down_d = 1'b1;
                end else begin
                    pen_down_d = 1'b0;
                end
                gap_cnt_d = '0;
                state_d   = ST_GAP;
            end

            ST_GAP: begin
                avg_clear = 1'b1;
                gap_cnt_d = gap_cnt + GAP_W'(1);
                if (gap_cnt == GAP_W'(SCAN_GAP - 1)) begin
                    gap_cnt_d = '0;
                    if (enable) begin
                        axis_d  = AXIS_X;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                txn_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_touch_scan_scheduler.sv
// Directed testbench for touch_scan_scheduler with a behavioural SPI engine.
`timescale 1ns/1ps
module tb_touch_scan_scheduler;

    localparam int SCAN_GAP = 5000;
    localparam int TIMEOUT  = 4096;

    logic        cclk = 1'b0;
    logic        rstb;
    logic        enable;
    logic        txn_req;
    logic [7:0]  txn_cmd;
    logic        txn_done;
    logic [11:0] txn_rdata;
    logic [11:0] x, y, z;
    logic        pen_down, sample_valid, timeout_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 cclk = ~cclk;

    touch_scan_scheduler dut (
        .cclk         (cclk),
        .rstb         (rstb),
        .enable       (enable),
        .txn_req      (txn_req),
        .txn_cmd      (txn_cmd),
        .txn_done     (txn_done),
        .txn_rdata    (txn_rdata),
        .x            (x),
        .y            (y),
        .z            (z),
        .pen_down     (pen_down),
        .sample_valid (sample_valid),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    // Cycle counter and event monitor (sampled on the falling edge)
    int   cyc = 0;
    int   sv_cnt = 0, sv_cyc = -1, te_cnt = 0, te_cyc = -1;
    int   rise_cnt = 0, rise_cyc = -1, fall_cyc = -1;
    logic req_prev = 1'b0;

    always @(posedge cclk) cyc <= cyc + 1;

    initial forever begin
        @(negedge cclk);
        if (sample_valid === 1'b1) begin sv_cnt++; sv_cyc = cyc; end
        if (timeout_err === 1'b1)  begin te_cnt++; te_cyc = cyc; end
        if (txn_req === 1'b1 && !req_prev) begin rise_cnt++; rise_cyc = cyc; end
        if (txn_req !== 1'b1 && req_prev) fall_cyc = cyc;
        req_prev = (txn_req === 1'b1);
    end

    // Behavioural engine: answers each request after eng_lat cycles
    logic        eng_on = 1'b0;
    logic        eng_idle = 1'b1;
    int          eng_lat = 30;
    logic [11:0] tbl_x [5];
    logic [11:0] tbl_y [5];
    logic [11:0] tbl_z [5];
    logic [7:0]  cmd_log [$];
    logic [7:0]  last_cmd = 8'h00;
    logic [7:0]  e_cmd;
    logic [11:0] e_data;
    int          e_idx = 0;
    int          done_cyc = -1;
    int          done_cnt = 0;

    initial begin
        txn_done  = 1'b0;
        txn_rdata = 12'h000;
        forever begin
            @(posedge cclk); #1;
            if (eng_on && txn_req === 1'b1) begin
                eng_idle = 1'b0;
                e_cmd = txn_cmd;
                cmd_log.push_back(e_cmd);
                if (e_cmd == last_cmd) e_idx = (e_idx + 1) % 5;
                else e_idx = 0;
                last_cmd = e_cmd;
                case (e_cmd)
                    8'hCB:   e_data = tbl_x[e_idx];
                    8'hC9:   e_data = tbl_y[e_idx];
                    default: e_data = tbl_z[e_idx];
                endcase
                repeat (eng_lat - 1) @(posedge cclk);
                #1;
                txn_done  = 1'b1;
                txn_rdata = e_data;
                done_cyc  = cyc;
                done_cnt++;
                @(posedge cclk); #1;
                txn_done  = 1'b0;
                txn_rdata = 12'h000;
                eng_idle  = 1'b1;
            end
        end
    end

    task automatic set_tables(input logic [11:0] xv, input logic [11:0] yv, input logic [11:0] zv);
        for (int i = 0; i < 5; i++) begin
            tbl_x[i] = xv;
            tbl_y[i] = yv;
            tbl_z[i] = zv;
        end
        last_cmd = 8'h00;
        e_idx    = 0;
    endtask

    task automatic wait_sv(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge cclk); #1;
            ok = (sv_cnt > base);
        end
    endtask

    task automatic wait_rise(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge cclk); #1;
            ok = (rise_cnt > base);
        end
    endtask

    task automatic wait_te(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge cclk); #1;
            ok = (te_cnt > base);
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge cclk); #1;
            ok = (busy === 1'b0);
        end
    endtask

    task automatic test_reset();
        rstb   = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge cclk);
        checks++;
        if ({x, y, z} !== {12'd1000, 12'd1000, 12'd1000}) begin
            errors++;
            $display("FAIL reset_xyz: got %0d/%0d/%0d expected 1000/1000/1000", x, y, z);
        end
        checks++;
        if ({pen_down, sample_valid, timeout_err, txn_req, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {pen_down, sample_valid, timeout_err, txn_req, busy});
        end
        checks++;
        if (txn_cmd !== 8'h00) begin
            errors++;
            $display("FAIL reset_cmd: got %h expected 00", txn_cmd);
        end
        rstb = 1'b1;
        @(negedge cclk);
    endtask

    task automatic test_basic_scan();
        bit         ok;
        int         base, bad, r0;
        logic [7:0] exp_cmd;
        set_tables(12'd100, 12'd200, 12'd300);
        eng_lat = 30;
        eng_on  = 1'b1;
        cmd_log.delete();
        base = sv_cnt;
        enable = 1'b1;
        wait_sv(base, 3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_publish: got no strobe expected one"); end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            exp_cmd = (i < 5) ? 8'hCB : (i < 10) ? 8'hC9 : 8'hCD;
            if (i >= cmd_log.size() || cmd_log[i] !== exp_cmd) bad++;
        end
        checks++;
        if (cmd_log.size() != 15 || bad != 0) begin
            errors++;
            $display("FAIL basic_cmd_seq: got %0d cmds %0d wrong expected 15 cmds 0 wrong",
                     cmd_log.size(), bad);
        end
        checks++;
        if ({x, y, z, pen_down} !== {12'd100, 12'd200, 12'd300, 1'b1}) begin
            errors++;
            $display("FAIL basic_coords: got %0d/%0d/%0d pen %b expected 100/200/300 pen 1",
                     x, y, z, pen_down);
        end
        checks++;
        if (sv_cyc - done_cyc != 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 2", sv_cyc - done_cyc);
        end
        @(negedge cclk); #1;
        checks++;
        if (sample_valid !== 1'b0 || sv_cnt != base + 1) begin
            errors++;
            $display("FAIL basic_single_strobe: got sv=%b count=%0d expected 0 and %0d",
                     sample_valid, sv_cnt - base, 1);
        end
        // GAP lasts SCAN_GAP cycles, then one ISSUE cycle before req rises
        r0 = rise_cnt;
        wait_rise(r0, SCAN_GAP + 100, ok);
        checks++;
        if (!ok || rise_cyc - sv_cyc != SCAN_GAP + 1) begin
            errors++;
            $display("FAIL basic_gap: got %0d expected %0d", rise_cyc - sv_cyc, SCAN_GAP + 1);
        end
        enable = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_stop: got busy=%b expected 0", busy); end
    endtask

    task automatic test_pen_up();
        bit ok;
        int base;
        set_tables(12'd555, 12'd666, 12'h050);
        eng_lat = 4;
        base = sv_cnt;
        enable = 1'b1;
        wait_sv(base, 1000, ok);
        enable = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL penup_publish: got no strobe expected one"); end
        checks++;
        if ({x, y, z, pen_down} !== {12'd100, 12'd200, 12'h050, 1'b0}) begin
            errors++;
            $display("FAIL penup_coords: got %0d/%0d/%h pen %b expected 100/200/050 pen 0",
                     x, y, z, pen_down);
        end
        wait_idle(SCAN_GAP + 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL penup_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_averaging();
        bit ok;
        int base;
        set_tables(12'd10, 12'd200, 12'h080);
        tbl_x[0] = 12'd999;
        tbl_x[1] = 12'd10;
        tbl_x[2] = 12'd11;
        tbl_x[3] = 12'd12;
        tbl_x[4] = 12'd13;
        base = sv_cnt;
        enable = 1'b1;
        wait_sv(base, 1000, ok);
        enable = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL avg_publish: got no strobe expected one"); end
        checks++;
        if (x !== 12'd11) begin
            errors++;
            $display("FAIL avg_trunc: got %0d expected 11", x);
        end
        // Z exactly at threshold counts as pen down
        checks++;
        if ({y, z, pen_down} !== {12'd200, 12'h080, 1'b1}) begin
            errors++;
            $display("FAIL avg_z_thresh: got y=%0d z=%h pen %b expected 200 080 1", y, z, pen_down);
        end
        wait_idle(SCAN_GAP + 100, ok);
    endtask

    task automatic test_timeout();
        bit ok;
        int base_te, base_sv, rr;
        eng_on  = 1'b0;
        base_te = te_cnt;
        base_sv = sv_cnt;
        enable  = 1'b1;
        wait_rise(rise_cnt, 20, ok);
        rr = rise_cyc;
        wait_te(base_te, TIMEOUT + 100, ok);
        checks++;
        if (!ok || te_cyc - rr != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected %0d", te_cyc - rr, TIMEOUT);
        end
        checks++;
        if (fall_cyc != te_cyc || txn_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_req_drop: got fall %0d req %b expected %0d req 0",
                     fall_cyc, txn_req, te_cyc);
        end
        @(negedge cclk); #1;
        checks++;
        if (timeout_err !== 1'b0 || sv_cnt != base_sv) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b publishes=%0d expected 0 and 0",
                     timeout_err, sv_cnt - base_sv);
        end
        wait_rise(rise_cnt, SCAN_GAP + 100, ok);
        checks++;
        if (!ok || rise_cyc - te_cyc != SCAN_GAP + 1) begin
            errors++;
            $display("FAIL timeout_retry: got %0d expected %0d", rise_cyc - te_cyc, SCAN_GAP + 1);
        end
        enable = 1'b0;
        eng_on = 1'b1;
        wait_idle(200, ok);
        checks++;
        if (!ok || {x, y} !== {12'd11, 12'd200}) begin
            errors++;
            $display("FAIL timeout_no_publish: got %0d/%0d busy %b expected 11/200 busy 0",
                     x, y, busy);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int base_sv, d0;
        set_tables(12'd700, 12'd800, 12'd900);
        eng_lat = 4;
        base_sv = sv_cnt;
        enable  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge cclk); #1;
            ok = (txn_req === 1'b1 && txn_cmd === 8'hC9);
        end
        d0 = done_cnt;
        enable = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL drop_reach_y: got cmd %h expected C9", txn_cmd); end
        wait_idle(100, ok);
        checks++;
        if (!ok || txn_req !== 1'b0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL drop_finish_txn: got busy %b req %b dones %0d expected 0 0 1",
                     busy, txn_req, done_cnt - d0);
        end
        checks++;
        if ({x, y, z, pen_down} !== {12'd11, 12'd200, 12'h080, 1'b1} || sv_cnt != base_sv) begin
            errors++;
            $display("FAIL drop_outputs_held: got %0d/%0d/%h pen %b expected 11/200/080 pen 1",
                     x, y, z, pen_down);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        set_tables(12'd700, 12'd800, 12'd900);
        eng_lat = 30;
        enable  = 1'b1;
        wait_rise(rise_cnt, 20, ok);
        repeat (3) @(negedge cclk);
        #2;
        rstb = 1'b0;
        #1;
        checks++;
        if (txn_req !== 1'b0 || x !== 12'd1000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got req %b x %0d busy %b expected 0 1000 0",
                     txn_req, x, busy);
        end
        enable = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge cclk);
            ok = eng_idle;
        end
        rstb = 1'b1;
        @(negedge cclk);
    endtask

    task automatic test_cal();
        bit          ok;
        int          base;
        logic [11:0] exp_x, exp_y;
`ifdef TOUCH_CAL_EN
        exp_x = 12'h000;
        exp_y = 12'hED3;
`else
        exp_x = 12'h050;
        exp_y = 12'hFFF;
`endif
        set_tables(12'h050, 12'hFFF, 12'h300);
        eng_lat = 4;
        base = sv_cnt;
        enable = 1'b1;
        wait_sv(base, 1000, ok);
        enable = 1'b0;
        checks++;
        if (!ok || {x, y, z} !== {exp_x, exp_y, 12'h300}) begin
            errors++;
            $display("FAIL cal_xy: got %h/%h/%h expected %h/%h/300", x, y, z, exp_x, exp_y);
        end
        wait_idle(SCAN_GAP + 100, ok);
    endtask

    initial begin
        rstb   = 1'b0;
        enable = 1'b0;
        test_reset();
        test_basic_scan();
        test_pen_up();
        test_averaging();
        test_timeout();
        test_enable_drop();
        test_async_reset();
        test_cal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
